req_arbiter_4ch: RTL and testbench
==================================

// Module: req_arbiter_4ch
// PURPOSE
//  Arbitrates one shared resource between 4 requesters using a registered req/gnt handshake.
//  Requester i holds req[i] high while it uses the resource. The grant is held until req[i] drops or the hold timer expires.
//  Two policies: fixed priority (req[3] highest, same order as the 4-to-2 priority encoder) or round-robin.
//  Sits in front of any shared datapath unit; gnt_id drives the unit's input mux select.
// PARAMETERS
//  RR_MODE   0  0 = fixed priority 3>2>1>0; 1 = round-robin
//  MAX_HOLD  8  max cycles a grant is held while req stays high; 0 = no timeout
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  reset, asynchronous, active-high
//  req        in   4  request vector, one bit per requester
//  gnt        out  4  one-hot grant, registered
//  gnt_id     out  2  encoded index of granted requester (valid when gnt_valid=1)
//  gnt_valid  out  1  |gnt
//  timeout    out  1  one-cycle pulse when a grant is force-released by the hold timer
// BEHAVIOUR
//  Reset (async, rst=1):
//   - gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
//   - State=IDLE, hold_cnt=0, mask=0, rr_last=0.
//   - Applies immediately, including mid-grant.
//  eligible = req & ~mask. Winner is chosen from eligible only.
//   - Fixed mode: highest set index wins.
//   - RR mode: search starts at index (rr_last-1) mod 4 and descends with wrap 0->3.
//   - After reset the RR search order is therefore 3,2,1,0.
//  FSM (IDLE, GRANT, RECOVER):
//   - IDLE: eligible!=0 -> GRANT. gnt/gnt_id/gnt_valid update at this edge, so latency is 1 cycle from sampled req to gnt.
//     hold_cnt=0; rr_last=winner. Otherwise stay in IDLE, gnt=0.
//   - GRANT: hold_cnt++ every cycle. Changes on other req bits are ignored; there is no preemption.
//     req[gnt_id]=0 -> RECOVER. gnt clears at this edge.
//     MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 with req[gnt_id]=1 -> RECOVER. gnt clears, timeout=1 for exactly 1 cycle, mask[gnt_id] sets.
//     If both conditions hold in the same cycle, the release wins: no timeout, no mask.
//   - RECOVER: gnt=0 for exactly one cycle (turnaround). Then arbitrates as in IDLE.
//     eligible!=0 -> GRANT; else -> IDLE.
//  Minimum gap between consecutive grants is one dead cycle.
//  Each grant lasts between 1 and MAX_HOLD cycles.
//  mask[i] clears on any edge where req[i]=0, in every state. A timed-out requester must drop req for at least 1 cycle before it can win again.
//  Hold counter width is $clog2(MAX_HOLD+1). It must not wrap within a grant.
//  gnt is always one-hot or zero. gnt_id holds its last value while gnt_valid=0.
// TESTING
//  1. RR_MODE=0: req=0110 held -> gnt=0100, gnt_id=2 one cycle later.
//     Drop req[2] -> next edge gnt=0000, then next edge gnt=0010, gnt_id=1.
//  2. RR_MODE=0: while gnt=0010, raise req[3] -> gnt stays 0010 until req[1] drops.
//     Then 1 dead cycle, then gnt=1000.
//  3. RR_MODE=1, req=1111: each granted requester drops its req for 1 cycle after 2 cycles of grant.
//     Grant order must be 3,2,1,0,3, with exactly 1 dead cycle between grants.
//  4. MAX_HOLD=4, req=1000 held: gnt=1000 for 4 cycles, then timeout=1 for 1 cycle and gnt=0.
//     No regrant while req[3] stays high. Drop req[3] for 1 cycle, reassert -> granted again.
//  5. Assert rst mid-grant (gnt=0100): gnt=0 and gnt_valid=0 without a clock edge.
//     After release with req=1111 in RR mode, the first grant is 1000.
//  6. req=0000 for 20 cycles after reset -> gnt_valid=0 and timeout=0 throughout.

Source files
------------

// File: rtl/req_arbiter_4ch.sv
// req_arbiter_4ch: four-requester arbiter for one shared resource.
// Registered req/gnt handshake with fixed-priority or round-robin selection,
// an optional hold timer that force-releases long grants, and one dead
// turnaround cycle between consecutive grants.
module req_arbiter_4ch #(
  parameter int unsigned RR_MODE  = 0,  // 0 = fixed priority 3>2>1>0, 1 = round-robin
  parameter int unsigned MAX_HOLD = 8   // max grant length in cycles, 0 = unlimited
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  // Keep at least one bit so MAX_HOLD = 0 still elaborates a legal counter.
  localparam int unsigned CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    st_idle,
    st_grant,
    st_recover
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic [3:0]      mask_q, mask_d;
  logic [1:0]      rr_last_q, rr_last_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      gnt_id_q, gnt_id_d;
  logic            timeout_q, timeout_d;

  logic [3:0]      eligible;
  logic [1:0]      winner;
  logic [1:0]      rr_start;
  logic [1:0]      rr_idx;
  logic            rr_found;
  logic [3:0]      mask_set;

  assign eligible = req & ~mask_q;
  assign rr_start = rr_last_q - 2'd1;

  // Winner selection from the eligible set; only used when eligible != 0.
  always_comb begin
    winner   = 2'd0;
    rr_idx   = 2'd0;
    rr_found = 1'b0;
    if (RR_MODE == 0) begin
      // Ascending scan so the highest set index is the last one kept.
      for (int i = 0; i < 4; i++) begin
        if (eligible[i]) winner = 2'(i);
      end
    end else begin
      // Descending scan with wrap, starting one below the last winner.
      for (int k = 0; k < 4; k++) begin
        rr_idx = rr_start - 2'(k);
        if (!rr_found && eligible[rr_idx]) begin
          winner   = rr_idx;
          rr_found = 1'b1;
        end
      end
    end
  end

  // Next-state logic for the grant FSM, hold timer and timeout mask.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    rr_last_d = rr_last_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    timeout_d = 1'b0;
    mask_set  = 4'b0000;
    unique case (state_q)
      st_idle, st_recover: begin
        if (|eligible) begin
          state_d   = st_grant;
          gnt_d     = 4'b0001 << winner;
          gnt_id_d  = winner;
          hold_d    = '0;
          rr_last_d = winner;
        end else begin
          state_d = st_idle;
          gnt_d   = 4'b0000;
        end
      end
      st_grant: begin
        // Saturate so an unlimited grant never wraps the counter.
        if (hold_q != '1) hold_d = hold_q + 1'b1;
        if (!req[gnt_id_q]) begin
          // Voluntary release takes precedence over the timer.
          state_d = st_recover;
          gnt_d   = 4'b0000;
        end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST)) begin
          state_d   = st_recover;
          gnt_d     = 4'b0000;
          timeout_d = 1'b1;
          mask_set  = gnt_q;
        end
      end
      default: begin
        state_d = st_idle;
        gnt_d   = 4'b0000;
      end
    endcase
    // A masked requester becomes eligible again once it has dropped req.
    mask_d = (mask_q & req) | mask_set;
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= st_idle;
      hold_q    <= '0;
      mask_q    <= 4'b0000;
      rr_last_q <= 2'd0;
      gnt_q     <= 4'b0000;
      gnt_id_q  <= 2'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      mask_q    <= mask_d;
      rr_last_q <= rr_last_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_req_arbiter_4ch.sv
// Directed testbench for req_arbiter_4ch. Three instances share clock and
// reset: fixed priority (hold 8), round-robin (hold 8), fixed priority (hold 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_req_arbiter_4ch;

  logic       clk;
  logic       rst;
  logic [3:0] req_a, req_b, req_c;
  logic [3:0] gnt_a, gnt_b, gnt_c;
  logic [1:0] id_a, id_b, id_c;
  logic       gv_a, gv_b, gv_c;
  logic       to_a, to_b, to_c;

  int tests;
  int errors;

  req_arbiter_4ch #(.RR_MODE(0), .MAX_HOLD(8)) u_fix (
    .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .gnt_id(id_a),
    .gnt_valid(gv_a), .timeout(to_a)
  );

  req_arbiter_4ch #(.RR_MODE(1), .MAX_HOLD(8)) u_rr (
    .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_id(id_b),
    .gnt_valid(gv_b), .timeout(to_b)
  );

  req_arbiter_4ch #(.RR_MODE(0), .MAX_HOLD(4)) u_to (
    .clk(clk), .rst(rst), .req(req_c), .gnt(gnt_c), .gnt_id(id_c),
    .gnt_valid(gv_c), .timeout(to_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [3:0] g [3];
    logic [1:0] d [3];
    logic       v [3];
    logic       t [3];
    g = '{gnt_a, gnt_b, gnt_c};
    d = '{id_a, id_b, id_c};
    v = '{gv_a, gv_b, gv_c};
    t = '{to_a, to_b, to_c};
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (g[i] !== 4'b0000 || d[i] !== 2'd0 || v[i] !== 1'b0 || t[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset inst%0d: gnt=%b id=%0d valid=%b to=%b, want 0/0/0/0",
                 i, g[i], d[i], v[i], t[i]);
      end
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      tests++;
      if ({gv_a, gv_b, gv_c, to_a, to_b, to_c} !== 6'b0) begin
        errors++;
        $display("FAIL idle cycle %0d: valid=%b%b%b to=%b%b%b, want all 0",
                 c, gv_a, gv_b, gv_c, to_a, to_b, to_c);
      end
    end
  endtask

  task automatic test_fixed_basic();
    req_a = 4'b0110;
    @(negedge clk);
    tests++;
    if (gnt_a !== 4'b0100 || id_a !== 2'd2 || gv_a !== 1'b1) begin
      errors++;
      $display("FAIL fixed first: gnt=%b id=%0d valid=%b, want 0100/2/1", gnt_a, id_a, gv_a);
    end
    req_a = 4'b0010;
    @(negedge clk);
    tests++;
    if (gnt_a !== 4'b0000 || gv_a !== 1'b0 || id_a !== 2'd2) begin
      errors++;
      $display("FAIL fixed dead: gnt=%b valid=%b id=%0d, want 0000/0/2", gnt_a, gv_a, id_a);
    end
    @(negedge clk);
    tests++;
    if (gnt_a !== 4'b0010 || id_a !== 2'd1) begin
      errors++;
      $display("FAIL fixed second: gnt=%b id=%0d, want 0010/1", gnt_a, id_a);
    end
  endtask

  // Continues from test_fixed_basic with requester 1 holding the grant.
  task automatic test_no_preempt();
    req_a = 4'b1010;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests++;
      if (gnt_a !== 4'b0010) begin
        errors++;
        $display("FAIL no_preempt hold %0d: gnt=%b, want 0010", c, gnt_a);
      end
    end
    req_a = 4'b1000;
    @(negedge clk);
    tests++;
    if (gnt_a !== 4'b0000) begin
      errors++;
      $display("FAIL no_preempt dead: gnt=%b, want 0000", gnt_a);
    end
    @(negedge clk);
    tests++;
    if (gnt_a !== 4'b1000 || id_a !== 2'd3) begin
      errors++;
      $display("FAIL no_preempt next: gnt=%b id=%0d, want 1000/3", gnt_a, id_a);
    end
    req_a = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rr_rotation();
    logic [1:0] order [5];
    logic [3:0] exp;
    order = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
    req_b = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << order[k];
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        tests++;
        if (gnt_b !== exp || id_b !== order[k]) begin
          errors++;
          $display("FAIL rr grant %0d cyc %0d: gnt=%b id=%0d, want %b/%0d",
                   k, c, gnt_b, id_b, exp, order[k]);
        end
      end
      req_b = 4'b1111 & ~exp;
      @(negedge clk);
      tests++;
      if (gnt_b !== 4'b0000) begin
        errors++;
        $display("FAIL rr dead %0d: gnt=%b, want 0000", k, gnt_b);
      end
      req_b = 4'b1111;
    end
    req_b = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    req_c = 4'b1000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++;
      if (gnt_c !== 4'b1000 || to_c !== 1'b0) begin
        errors++;
        $display("FAIL timeout hold %0d: gnt=%b to=%b, want 1000/0", c, gnt_c, to_c);
      end
    end
    @(negedge clk);
    tests++;
    if (gnt_c !== 4'b0000 || to_c !== 1'b1) begin
      errors++;
      $display("FAIL timeout pulse: gnt=%b to=%b, want 0000/1", gnt_c, to_c);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++;
      if (gnt_c !== 4'b0000 || to_c !== 1'b0) begin
        errors++;
        $display("FAIL timeout masked %0d: gnt=%b to=%b, want 0000/0", c, gnt_c, to_c);
      end
    end
    req_c = 4'b0000;
    @(negedge clk);
    req_c = 4'b1000;
    @(negedge clk);
    tests++;
    if (gnt_c !== 4'b1000) begin
      errors++;
      $display("FAIL timeout regrant: gnt=%b, want 1000", gnt_c);
    end
  endtask

  // Continues from test_timeout: drop req exactly on the last allowed cycle.
  task automatic test_release_wins();
    repeat (3) @(negedge clk);
    tests++;
    if (gnt_c !== 4'b1000) begin
      errors++;
      $display("FAIL release_wins last cycle: gnt=%b, want 1000", gnt_c);
    end
    req_c = 4'b0000;
    @(negedge clk);
    tests++;
    if (gnt_c !== 4'b0000 || to_c !== 1'b0) begin
      errors++;
      $display("FAIL release_wins no timeout: gnt=%b to=%b, want 0000/0", gnt_c, to_c);
    end
    req_c = 4'b1000;
    @(negedge clk);
    tests++;
    if (gnt_c !== 4'b1000) begin
      errors++;
      $display("FAIL release_wins not masked: gnt=%b, want 1000", gnt_c);
    end
    req_c = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    req_b = 4'b0100;
    @(negedge clk);
    tests++;
    if (gnt_b !== 4'b0100) begin
      errors++;
      $display("FAIL async setup: gnt=%b, want 0100", gnt_b);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (gnt_b !== 4'b0000 || gv_b !== 1'b0 || id_b !== 2'd0) begin
      errors++;
      $display("FAIL async clear: gnt=%b valid=%b id=%0d, want 0000/0/0", gnt_b, gv_b, id_b);
    end
    @(negedge clk);
    rst   = 1'b0;
    req_b = 4'b1111;
    @(negedge clk);
    tests++;
    if (gnt_b !== 4'b1000 || id_b !== 2'd3) begin
      errors++;
      $display("FAIL async first rr: gnt=%b id=%0d, want 1000/3", gnt_b, id_b);
    end
    req_b = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    tests  = 0;
    errors = 0;
    rst    = 1'b1;
    req_a  = 4'b0000;
    req_b  = 4'b0000;
    req_c  = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_idle();
    test_fixed_basic();
    test_no_preempt();
    test_rr_rotation();
    test_timeout();
    test_release_wins();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
